lcd_msg_composer: RTL and testbench
===================================

Name: lcd_msg_composer

Overview:
- Upstream feeder for the LCD display controller.
- Owns the 32-character display buffer: addresses 0-15 are row 1, addresses 16-31 are row 2.
- Fills the buffer from a fixed message ROM when the safe FSM selects a message.
- Overlays a 4-digit BCD "MM:SS" timer field on messages flagged as timed.
- The LCD controller reads the buffer through a combinational address/data port.

Parameters:
- NUM_MSGS, 8, number of ROM messages; msg_sel width is clog2(NUM_MSGS).
- TIME_BASE, 27, buffer address of the first timer character (row 2, col 11).
- FILL_CHAR, 8'h20, character written to the buffer during reset init (space).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- msg_sel  in  3  message index; sampled only when msg_load=1.
- msg_load  in  1  one-cycle request to copy message msg_sel into the buffer.
- digits  in  16  BCD timer value {M1,M0,S1,S0}; sampled only when digits_valid=1.
- digits_valid  in  1  one-cycle request to update the timer field.
- rd_addr  in  5  LCD controller read address.
- rd_data  out  8  buffer[rd_addr], combinational.
- busy  out  1  high while INIT, COPY or DIGITS is active.
- load_done  out  1  one-cycle pulse when a message copy, including any auto-overlay, completes.

Behaviour:
- State machine: INIT, IDLE, COPY, DIGITS. The buffer allows one write per cycle.
- Reset:
  - state=INIT, write address=0, busy=1, load_done=0.
  - Pending flags cleared, latched digits=16'h0000, current msg=0, timed flag=0.
  - Reset mid-operation abandons any copy or overlay and restarts INIT.
- INIT: writes FILL_CHAR to addresses 0..31, one per cycle (32 cycles). Then goes to IDLE with busy=0. Requests arriving during INIT are latched as pending.
- IDLE, msg_load=1:
  - Latch msg_sel and its timed flag from the ROM.
  - Enter COPY; busy=1 from the next cycle.
- COPY:
  - Writes ROM[msg][i] to address i for i=0..31, one per cycle, so exactly 32 write cycles.
  - After i=31: if timed, or a digit update is pending, enter DIGITS. Otherwise enter IDLE, pulse load_done and drop busy on the same cycle.
- DIGITS:
  - Writes 5 cycles to TIME_BASE+0..4: M1, M0, ':', S1, S0.
  - Each digit is written as 8'h30+nibble. A nibble >9 is written as '?' (8'h3F).
  - Only runs when the current message is timed. Otherwise the digits are latched and no write occurs.
  - When DIGITS follows a COPY, load_done pulses at its end. When it runs standalone, load_done is not pulsed.
- IDLE, digits_valid=1: latch digits. If the current message is timed, enter DIGITS; otherwise stay in IDLE.
- Simultaneous msg_load and digits_valid in IDLE: latch both, run COPY first. DIGITS then follows if the new message is timed.
- msg_load during COPY: latch the new msg_sel and restart COPY at address 0. No load_done is produced for the aborted copy.
- msg_load during DIGITS: set pending. The current 5 writes complete, then COPY starts.
- digits_valid during COPY or DIGITS: latch digits (last value wins) and set digit-pending. It is serviced after the current operation.
- Priority when leaving IDLE or DIGITS: pending copy before pending digits.
- Buffer writes never go outside 0..31. The write address is 5 bits and is reset on each operation entry, never wrapping.
- rd_data reflects a write on the cycle after the write edge. Mid-update reads are permitted and are visible as a mixed old/new message. Preventing this is the controller's concern.

Decomposition:
- Package lcd_msg_pkg:
  - ASCII constants (SPACE, COLON, QMARK, ZERO).
  - State encodings.
  - TIME_BASE default.
  - Message ROM function msg_char(idx,pos) returning 8 bits.
  - Timed-flag function msg_timed(idx). Messages: 0 "ENTER CODE", 1 "LOCKED" (timed), 2 "OPEN", 3 "WRONG CODE", 4 "SET NEW CODE", 5-7 blank.
- Sub-module lcd_char_buffer: 32x8 register array, one synchronous write port, one asynchronous read port. The composer FSM instantiates it.

Test Plan:
- Reset, then hold idle:
  - busy=1 for exactly 32 cycles, then 0.
  - All 32 rd_addr reads return 8'h20.
  - load_done never pulses.
- msg_load with msg_sel=0 in IDLE:
  - busy high for 32 cycles, then load_done pulses once.
  - rd_addr 0..9 read "ENTER CODE" and address 10 reads 8'h20.
- msg_sel=1 (timed) with digits=16'h0259 latched earlier:
  - 32+5 busy cycles, then load_done.
  - Addresses 27..31 read "02:59" (8'h30,32,3A,35,39).
- digits_valid with 16'h0A05 while LOCKED is shown:
  - 5 busy cycles and no load_done.
  - Addresses 27..31 read 8'h30,3F,3A,30,35.
- msg_load at COPY write 10, then digits_valid with message 0 shown:
  - The copy restarts with the new message and load_done fires exactly once.
  - The non-timed message leaves 27..31 unchanged.
- Assert rst_n=0 at COPY write 20:
  - Next cycle state=INIT, busy=1.
  - After 32 cycles all addresses read 8'h20 and the pending request is discarded.

Source files
------------

// File: rtl/lcd_msg_pkg.sv
// Shared constants, state encoding and message ROM for the LCD message composer.
// The ROM is a pure function so that the composer reads it combinationally with no storage.
package lcd_msg_pkg;

   localparam int NUM_MSGS      = 8;
   localparam int MSG_W         = $clog2(NUM_MSGS);
   localparam int ADDR_W        = 5;
   localparam int BUF_DEPTH     = 32;
   localparam int TIME_BASE_DEF = 27;

   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] COLON = 8'h3A;
   localparam logic [7:0] QMARK = 8'h3F;
   localparam logic [7:0] ZERO  = 8'h30;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_COPY   = 2'd2,
      ST_DIGITS = 2'd3
   } state_t;

   function automatic logic msg_timed(input logic [MSG_W-1:0] idx);
      return idx == MSG_W'(1);
   endfunction

   // Only row 1 holds text; row 2 is blank so the timer field starts from spaces.
   function automatic logic [7:0] msg_char(input logic [MSG_W-1:0] idx,
                                           input logic [ADDR_W-1:0] pos);
      logic [127:0] row;
      case (idx)
         3'd0:    row = {"ENTER CODE", {6{SPACE}}};
         3'd1:    row = {"LOCKED", {10{SPACE}}};
         3'd2:    row = {"OPEN", {12{SPACE}}};
         3'd3:    row = {"WRONG CODE", {6{SPACE}}};
         3'd4:    row = {"SET NEW CODE", {4{SPACE}}};
         default: row = {16{SPACE}};
      endcase
      if (pos[4]) return SPACE;
      return row[{4'd15 - pos[3:0], 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] bcd_char(input logic [3:0] nib);
      return (nib > 4'd9) ? QMARK : ZERO + {4'h0, nib};
   endfunction

endpackage

// File: rtl/lcd_char_buffer.sv
// 32x8 display character store: one synchronous write port, one asynchronous read port.
module lcd_char_buffer
   import lcd_msg_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem_q [BUF_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_msg_composer.sv
// Fills the LCD character buffer from the message ROM and overlays an MM:SS timer
// field on timed messages; the LCD controller reads the buffer combinationally.
module lcd_msg_composer
   import lcd_msg_pkg::*;
#(
   parameter int         TIME_BASE = TIME_BASE_DEF,
   parameter logic [7:0] FILL_CHAR = SPACE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [MSG_W-1:0] msg_sel,
   input  logic             msg_load,
   input  logic [15:0]      digits,
   input  logic             digits_valid,
   input  logic [4:0]       rd_addr,
   output logic [7:0]       rd_data,
   output logic             busy,
   output logic             load_done
);

   localparam logic [ADDR_W-1:0] TB_ADDR  = ADDR_W'(TIME_BASE);
   localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(BUF_DEPTH - 1);
   localparam logic [ADDR_W-1:0] LAST_DIG = ADDR_W'(4);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [MSG_W-1:0]  msg_q, msg_d;
   logic              timed_q, timed_d;
   logic [15:0]       digits_q, digits_d;
   logic              pend_copy_q, pend_copy_d;
   logic              pend_dig_q, pend_dig_d;
   logic              from_copy_q, from_copy_d;
   logic              load_done_q, load_done_d;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;
   logic              leave;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      msg_d       = msg_q;
      timed_d     = timed_q;
      digits_d    = digits_q;
      pend_copy_d = pend_copy_q;
      pend_dig_d  = pend_dig_q;
      from_copy_d = from_copy_q;
      load_done_d = 1'b0;
      we          = 1'b0;
      waddr       = addr_q;
      wdata       = FILL_CHAR;
      leave       = 1'b0;

      // Requests are always latched; the state decides whether they act now or wait.
      if (msg_load) begin
         msg_d   = msg_sel;
         timed_d = msg_timed(msg_sel);
      end
      if (digits_valid) digits_d = digits;

      case (state_q)
         ST_INIT: begin
            we = 1'b1;
            if (msg_load)     pend_copy_d = 1'b1;
            if (digits_valid) pend_dig_d  = 1'b1;
            addr_d = addr_q + 1'b1;
            if (addr_q == LAST_POS) leave = 1'b1;
         end
         ST_IDLE: begin
            addr_d = '0;
            if (msg_load) begin
               state_d = ST_COPY;
            end else if (digits_valid && timed_q) begin
               state_d     = ST_DIGITS;
               from_copy_d = 1'b0;
            end
         end
         ST_COPY: begin
            we     = 1'b1;
            wdata  = msg_char(msg_q, addr_q);
            addr_d = addr_q + 1'b1;
            if (msg_load) begin
               addr_d = '0;
            end else if (addr_q == LAST_POS) begin
               addr_d     = '0;
               pend_dig_d = 1'b0;
               if (timed_q) begin
                  state_d     = ST_DIGITS;
                  from_copy_d = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  load_done_d = 1'b1;
               end
            end
         end
         ST_DIGITS: begin
            we    = 1'b1;
            waddr = TB_ADDR + addr_q;
            case (addr_q)
               5'd0:    wdata = bcd_char(digits_q[15:12]);
               5'd1:    wdata = bcd_char(digits_q[11:8]);
               5'd2:    wdata = COLON;
               5'd3:    wdata = bcd_char(digits_q[7:4]);
               default: wdata = bcd_char(digits_q[3:0]);
            endcase
            if (msg_load)     pend_copy_d = 1'b1;
            if (digits_valid) pend_dig_d  = 1'b1;
            addr_d = addr_q + 1'b1;
            if (addr_q == LAST_DIG) begin
               load_done_d = from_copy_q;
               leave       = 1'b1;
            end
         end
         default: state_d = ST_INIT;
      endcase

      // Pending copy wins over pending digits when an operation finishes.
      if (leave) begin
         addr_d = '0;
         if (pend_copy_d) begin
            state_d     = ST_COPY;
            pend_copy_d = 1'b0;
            pend_dig_d  = 1'b0;
         end else if (pend_dig_d && timed_d) begin
            state_d     = ST_DIGITS;
            from_copy_d = 1'b0;
            pend_dig_d  = 1'b0;
         end else begin
            state_d    = ST_IDLE;
            pend_dig_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         addr_q      <= '0;
         msg_q       <= '0;
         timed_q     <= 1'b0;
         digits_q    <= 16'h0000;
         pend_copy_q <= 1'b0;
         pend_dig_q  <= 1'b0;
         from_copy_q <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         msg_q       <= msg_d;
         timed_q     <= timed_d;
         digits_q    <= digits_d;
         pend_copy_q <= pend_copy_d;
         pend_dig_q  <= pend_dig_d;
         from_copy_q <= from_copy_d;
         load_done_q <= load_done_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign load_done = load_done_q;

   lcd_char_buffer u_buf (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_lcd_msg_composer.sv
// Directed and randomized bench for lcd_msg_composer against a text-level model of the display.
module tb_lcd_msg_composer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  msg_sel;
   logic        msg_load;
   logic [15:0] digits;
   logic        digits_valid;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        busy;
   logic        load_done;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [7:0]  exp_buf [32];
   logic [15:0] lat_dig;
   int          cur_msg;

   string texts [8] = '{"ENTER CODE", "LOCKED", "OPEN", "WRONG CODE",
                        "SET NEW CODE", "", "", ""};

   lcd_msg_composer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .msg_sel      (msg_sel),
      .msg_load     (msg_load),
      .digits       (digits),
      .digits_valid (digits_valid),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .load_done    (load_done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] ref_char(input int m, input int pos);
      if (pos < texts[m].len()) return texts[m][pos];
      return 8'h20;
   endfunction

   function automatic logic [7:0] ref_digit(input logic [3:0] n);
      if (n > 9) return 8'h3F;
      return 8'h30 + 8'(n);
   endfunction

   function automatic bit ref_timed(input int m);
      return m == 1;
   endfunction

   task automatic model_overlay(input logic [15:0] d);
      exp_buf[27] = ref_digit(d[15:12]);
      exp_buf[28] = ref_digit(d[11:8]);
      exp_buf[29] = 8'h3A;
      exp_buf[30] = ref_digit(d[7:4]);
      exp_buf[31] = ref_digit(d[3:0]);
   endtask

   task automatic model_load(input int m);
      for (int a = 0; a < 32; a++) exp_buf[a] = ref_char(m, a);
      cur_msg = m;
      if (ref_timed(m)) model_overlay(lat_dig);
   endtask

   task automatic model_blank();
      for (int a = 0; a < 32; a++) exp_buf[a] = 8'h20;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_buf(input string tag);
      for (int a = 0; a < 32; a++) begin
         rd_addr = 5'(a);
         #2;
         check($sformatf("%s[%0d]", tag, a), {24'h0, rd_data}, {24'h0, exp_buf[a]});
         @(negedge clk);
      end
   endtask

   // ---------------- driver ----------------
   // Issues a request at the current negedge, optionally injects a second request
   // inj_at cycles later, and counts busy samples and load_done pulses until idle.
   task automatic do_req(input logic ld, input logic [2:0] m, input logic dv,
                         input logic [15:0] d, input int inj_at, input logic inj_ld,
                         input logic [2:0] inj_m, input logic inj_dv,
                         input logic [15:0] inj_d, output int nb, output int nd);
      msg_load = ld; msg_sel = m; digits_valid = dv; digits = d;
      nb = 0; nd = 0;
      @(negedge clk);
      msg_load = 1'b0; digits_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (i == inj_at) begin
            msg_load = inj_ld; msg_sel = inj_m; digits_valid = inj_dv; digits = inj_d;
         end
         if (i == inj_at + 1) begin
            msg_load = 1'b0; digits_valid = 1'b0;
         end
         if (load_done) nd++;
         if (!busy) break;
         nb++;
         @(negedge clk);
      end
      msg_load = 1'b0; digits_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (load_done) nd++;
      end
   endtask

   task automatic count_init(output int nb, output int nd);
      nb = 0; nd = 0;
      for (int i = 0; i < 100; i++) begin
         if (load_done) nd++;
         if (!busy) break;
         nb++;
         @(negedge clk);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nb, nd, op, exp_nb;
      logic [2:0]  rm;
      logic [15:0] rd;
      logic        rdv;

      rst_n = 1'b0; msg_sel = '0; msg_load = 1'b0; digits = '0; digits_valid = 1'b0;
      rd_addr = '0; lat_dig = 16'h0000; cur_msg = 0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'h0, busy}, 32'd1);
      check("reset_done", {31'h0, load_done}, 32'd0);

      rst_n = 1'b1;
      count_init(nb, nd);
      check("init_busy_cycles", nb, 32'd32);
      check("init_load_done", nd, 32'd0);
      model_blank();
      check_buf("init_buf");

      // digit update while a non-timed message is current: latched, no write
      do_req(1'b0, 3'd0, 1'b1, 16'h0259, -1, 1'b0, 3'd0, 1'b0, 16'h0, nb, nd);
      lat_dig = 16'h0259;
      check("dig_untimed_busy", nb, 32'd0);
      check("dig_untimed_done", nd, 32'd0);
      check_buf("dig_untimed_buf");

      do_req(1'b1, 3'd0, 1'b0, 16'h0, -1, 1'b0, 3'd0, 1'b0, 16'h0, nb, nd);
      model_load(0);
      check("load0_busy", nb, 32'd32);
      check("load0_done", nd, 32'd1);
      check_buf("load0_buf");

      do_req(1'b1, 3'd1, 1'b0, 16'h0, -1, 1'b0, 3'd0, 1'b0, 16'h0, nb, nd);
      model_load(1);
      check("load1_busy", nb, 32'd37);
      check("load1_done", nd, 32'd1);
      check_buf("load1_buf");

      do_req(1'b0, 3'd0, 1'b1, 16'h0A05, -1, 1'b0, 3'd0, 1'b0, 16'h0, nb, nd);
      lat_dig = 16'h0A05;
      model_overlay(lat_dig);
      check("dig_timed_busy", nb, 32'd5);
      check("dig_timed_done", nd, 32'd0);
      check_buf("dig_timed_buf");

      // msg 3 copy restarted with msg 0 just before write 10 lands
      do_req(1'b1, 3'd3, 1'b0, 16'h0, 10, 1'b1, 3'd0, 1'b0, 16'h0, nb, nd);
      model_load(0);
      check("restart_busy", nb, 32'd43);
      check("restart_done", nd, 32'd1);
      check_buf("restart_buf");

      do_req(1'b0, 3'd0, 1'b1, 16'h1337, -1, 1'b0, 3'd0, 1'b0, 16'h0, nb, nd);
      lat_dig = 16'h1337;
      check("restart_dig_busy", nb, 32'd0);
      check("restart_dig_done", nd, 32'd0);
      check_buf("restart_dig_buf");

      // digit update during the copy of a timed message: newest digits appear
      do_req(1'b1, 3'd1, 1'b0, 16'h0, 5, 1'b0, 3'd0, 1'b1, 16'h4518, nb, nd);
      lat_dig = 16'h4518;
      model_load(1);
      check("copy_dig_busy", nb, 32'd37);
      check("copy_dig_done", nd, 32'd1);
      check_buf("copy_dig_buf");

      // msg_load during the overlay queues a copy behind it
      do_req(1'b1, 3'd1, 1'b0, 16'h0, 33, 1'b1, 3'd4, 1'b0, 16'h0, nb, nd);
      model_load(4);
      check("pend_copy_busy", nb, 32'd69);
      check("pend_copy_done", nd, 32'd2);
      check_buf("pend_copy_buf");

      // reset in the middle of a copy with a digit update latched
      msg_sel = 3'd3; msg_load = 1'b1;
      @(negedge clk);
      msg_load = 1'b0;
      repeat (14) @(negedge clk);
      digits = 16'h5959; digits_valid = 1'b1;
      @(negedge clk);
      digits_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", {31'h0, busy}, 32'd1);
      check("midrst_done", {31'h0, load_done}, 32'd0);
      rst_n = 1'b1;
      count_init(nb, nd);
      check("midrst_init_busy", nb, 32'd32);
      check("midrst_init_done", nd, 32'd0);
      lat_dig = 16'h0000;
      cur_msg = 0;
      model_blank();
      check_buf("midrst_buf");

      do_req(1'b1, 3'd1, 1'b0, 16'h0, -1, 1'b0, 3'd0, 1'b0, 16'h0, nb, nd);
      model_load(1);
      check("post_rst_busy", nb, 32'd37);
      check("post_rst_done", nd, 32'd1);
      check_buf("post_rst_buf");

      for (int it = 0; it < 8; it++) begin
         op  = $urandom_range(0, 2);
         rm  = 3'($urandom_range(0, 7));
         rd  = 16'($urandom);
         rdv = 1'($urandom_range(0, 1));
         if (op != 0) begin
            do_req(1'b1, rm, rdv, rd, -1, 1'b0, 3'd0, 1'b0, 16'h0, nb, nd);
            if (rdv) lat_dig = rd;
            model_load(int'(rm));
            exp_nb = ref_timed(int'(rm)) ? 37 : 32;
            check($sformatf("rnd%0d_load_busy", it), nb, exp_nb);
            check($sformatf("rnd%0d_load_done", it), nd, 32'd1);
         end else begin
            do_req(1'b0, rm, 1'b1, rd, -1, 1'b0, 3'd0, 1'b0, 16'h0, nb, nd);
            lat_dig = rd;
            exp_nb = 0;
            if (ref_timed(cur_msg)) begin
               model_overlay(lat_dig);
               exp_nb = 5;
            end
            check($sformatf("rnd%0d_dig_busy", it), nb, exp_nb);
            check($sformatf("rnd%0d_dig_done", it), nd, 32'd0);
         end
         check_buf($sformatf("rnd%0d_buf", it));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
